// File: rtl/mv_pkg.sv
// Shared definitions for the matrix-vector core and its data loader.
//   - Default ROWS/COLS/DATA_W/ADDR_W constants used by the core and the loader.
//   - Loader FSM state encoding.
//   - Counter width helper.
// The CHECK state only exists when MV_LOADER_CHECKSUM_EN is defined.
package mv_pkg;

  localparam int MV_ROWS   = 10;
  localparam int MV_COLS   = 10;
  localparam int MV_DATA_W = 32;
  localparam int MV_ADDR_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_MAT = 3'd1,
    ST_LOAD_VEC = 3'd2,
`ifdef MV_LOADER_CHECKSUM_EN
    ST_CHECK    = 3'd3,
`endif
    ST_GO       = 3'd4
  } ld_state_e;

  // Width of a counter that must reach depth-1; never narrower than one bit.
  function automatic int cnt_width(input int depth);
    if (depth > 1) begin
      return $clog2(depth);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/mv_checksum.sv
// Running modulo-2^DATA_W sum of the words streamed into the data memories.
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   synchronous active-low reset
//   clr    in   restart the sum at zero (new load)
//   add    in   add data to the sum this cycle
//   data   in   word to accumulate
//   beat   in   checksum word supplied by the host
//   match  out  beat equals the current sum (combinational compare)
// Only instantiated when MV_LOADER_CHECKSUM_EN is defined.
module mv_checksum #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              add,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] beat,
  output logic              match
);

  logic [DATA_W-1:0] sum_r;

  // Accumulator: cleared at the start of a load, wraps naturally at 2^DATA_W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_r <= '0;
    end else if (clr) begin
      sum_r <= '0;
    end else if (add) begin
      sum_r <= sum_r + data;
    end
  end

  assign match = (beat == sum_r);

endmodule

// File: rtl/mv_data_loader.sv
// Loads the matrix-vector core's data memories from a valid/ready word stream.
// The first ROWS*COLS words go to matrix memory (row-major), the next COLS
// words go to vector memory, then cpu_go pulses once to release the core.
// Optional feature: define MV_LOADER_CHECKSUM_EN to require a trailing
// checksum beat (sum of all loaded words); a mismatch raises sticky err and
// suppresses cpu_go.
// Ports:
//   clk, rst_n         clock and synchronous active-low reset
//   start              begin a load (only honoured in IDLE)
//   in_valid, in_data  stream word and its valid
//   in_ready           loader accepts a word this cycle
//   mat_we, vec_we     write strobes for matrix / vector memory
//   wr_addr, wr_data   address and data of the active write
//   busy               high outside IDLE
//   cpu_go             one-cycle completion pulse
//   err                sticky checksum mismatch (0 without the checksum build)
// All outputs are registered.
module mv_data_loader
  import mv_pkg::*;
#(
  parameter int ROWS   = MV_ROWS,
  parameter int COLS   = MV_COLS,
  parameter int DATA_W = MV_DATA_W,
  parameter int ADDR_W = MV_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mat_we,
  output logic              vec_we,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              cpu_go,
  output logic              err
);

  localparam int              CNT_W    = cnt_width(ROWS * COLS);
  localparam logic [CNT_W-1:0] MAT_LAST = CNT_W'(ROWS * COLS - 1);
  localparam logic [CNT_W-1:0] VEC_LAST = CNT_W'(COLS - 1);

  ld_state_e         state_r;
  ld_state_e         state_next_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              accept_s;
  logic              start_s;
  logic              mat_acc_s;
  logic              vec_acc_s;
  logic              chk_fail_s;
  logic              ready_next_s;

  logic              in_ready_r;
  logic              mat_we_r;
  logic              vec_we_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [DATA_W-1:0] wr_data_r;
  logic              busy_r;
  logic              cpu_go_r;
  logic              err_r;

  // in_ready_r is high exactly while the registered state is a load state,
  // so it doubles as the acceptance qualifier.
  assign accept_s  = in_valid && in_ready_r;
  assign start_s   = (state_r == ST_IDLE) && start;
  assign mat_acc_s = accept_s && (state_r == ST_LOAD_MAT);
  assign vec_acc_s = accept_s && (state_r == ST_LOAD_VEC);

`ifdef MV_LOADER_CHECKSUM_EN
  logic sum_match_s;

  mv_checksum #(
    .DATA_W (DATA_W)
  ) u_checksum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_s),
    .add   (mat_acc_s || vec_acc_s),
    .data  (in_data),
    .beat  (in_data),
    .match (sum_match_s)
  );

  assign chk_fail_s = accept_s && (state_r == ST_CHECK) && !sum_match_s;
`else
  assign chk_fail_s = 1'b0;
`endif

  // Next-state logic for the load sequence.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_LOAD_MAT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD_MAT: begin
        if (mat_acc_s && (cnt_r == MAT_LAST)) begin
          state_next_s = ST_LOAD_VEC;
        end else begin
          state_next_s = ST_LOAD_MAT;
        end
      end
      ST_LOAD_VEC: begin
        if (vec_acc_s && (cnt_r == VEC_LAST)) begin
`ifdef MV_LOADER_CHECKSUM_EN
          state_next_s = ST_CHECK;
`else
          state_next_s = ST_GO;
`endif
        end else begin
          state_next_s = ST_LOAD_VEC;
        end
      end
`ifdef MV_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (accept_s && sum_match_s) begin
          state_next_s = ST_GO;
        end else if (accept_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_CHECK;
        end
      end
`endif
      ST_GO: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Ready is registered from the next state so it lines up with the state register.
  always_comb begin
    ready_next_s = 1'b0;
    case (state_next_s)
      ST_LOAD_MAT: ready_next_s = 1'b1;
      ST_LOAD_VEC: ready_next_s = 1'b1;
`ifdef MV_LOADER_CHECKSUM_EN
      ST_CHECK:    ready_next_s = 1'b1;
`endif
      default:     ready_next_s = 1'b0;
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      in_ready_r <= 1'b0;
      mat_we_r   <= 1'b0;
      vec_we_r   <= 1'b0;
      wr_addr_r  <= '0;
      wr_data_r  <= '0;
      busy_r     <= 1'b0;
      cpu_go_r   <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      in_ready_r <= ready_next_s;
      busy_r     <= (state_next_s != ST_IDLE);
      // GO lasts one cycle; the pulse follows it so it lands one cycle
      // after the final write strobe.
      cpu_go_r   <= (state_r == ST_GO);
      mat_we_r   <= mat_acc_s;
      vec_we_r   <= vec_acc_s;
      if (mat_acc_s || vec_acc_s) begin
        wr_addr_r <= ADDR_W'(cnt_r);
        wr_data_r <= in_data;
      end
      // The counter restarts at zero for the vector phase instead of wrapping.
      if (start_s) begin
        cnt_r <= '0;
      end else if ((mat_acc_s && (cnt_r == MAT_LAST)) || (vec_acc_s && (cnt_r == VEC_LAST))) begin
        cnt_r <= '0;
      end else if (mat_acc_s || vec_acc_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      if (start_s) begin
        err_r <= 1'b0;
      end else if (chk_fail_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign in_ready = in_ready_r;
  assign mat_we   = mat_we_r;
  assign vec_we   = vec_we_r;
  assign wr_addr  = wr_addr_r;
  assign wr_data  = wr_data_r;
  assign busy     = busy_r;
  assign cpu_go   = cpu_go_r;
  assign err      = err_r;

endmodule

// File: tb/tb_mv_data_loader.sv
// Scoreboard bench for mv_data_loader with ROWS = COLS = 2.
// Stimulus pushes the expected writes / cpu_go pulse into a queue; a monitor
// thread pops and compares whenever a strobe is seen on the falling edge.
module tb_mv_data_loader;

  localparam int ROWS   = 2;
  localparam int COLS   = 2;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              mat_we;
  logic              vec_we;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              cpu_go;
  logic              err;

  typedef struct packed {
    logic [1:0]        kind;  // 0 matrix write, 1 vector write, 2 cpu_go
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   go_cyc = 0;
  int   go_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  mv_data_loader #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mat_we   (mat_we),
    .vec_we   (vec_we),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .cpu_go   (cpu_go),
    .err      (err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input logic [1:0] kind, input int addr, input int data);
    exp_t e;
    e.kind = kind;
    e.addr = ADDR_W'(addr);
    e.data = DATA_W'(data);
    exp_q.push_back(e);
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) step();
    check("sb_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // Start a load and stream words 1..6; gap inserts one idle cycle between words.
  task automatic stream(input bit gap, input int restart_idx, output int start_cyc);
    start = 1'b1;
    start_cyc = cyc;
    step();
    start = 1'b0;
    for (int k = 0; k < ROWS * COLS + COLS; k++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'(k + 1);
      start    = (k == restart_idx);
      if (k < ROWS * COLS) push(2'd0, k, k + 1);
      else push(2'd1, k - ROWS * COLS, k + 1);
      step();
      start = 1'b0;
      if (gap && k < ROWS * COLS + COLS - 1) begin
        in_valid = 1'b0;
        step();
      end
    end
    in_valid = 1'b0;
  endtask

  // Complete a load (good checksum in the checksum build) and check cpu_go timing.
  task automatic finish_load(input int start_cyc, input int exp_lat);
    int lat;
    int go_before;
    go_before = go_cnt;
    lat = exp_lat;
`ifdef MV_LOADER_CHECKSUM_EN
    in_valid = 1'b1;
    in_data  = 32'd21;
    push(2'd2, 0, 0);
    step();
    in_valid = 1'b0;
    lat = exp_lat + 1;
`else
    push(2'd2, 0, 0);
`endif
    drain(30);
    check("go_latency", 64'(go_cyc - start_cyc), 64'(lat));
    check("go_count", 64'(go_cnt - go_before), 64'd1);
    check("err_clear", 64'(err), 64'd0);
    check("busy_done", 64'(busy), 64'd0);
  endtask

  initial begin
    int sc;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;

    fork
      forever begin
        exp_t       e;
        logic [1:0] k;
        @(negedge clk);
        if (mat_we || vec_we || cpu_go) begin
          k = cpu_go ? 2'd2 : (vec_we ? 2'd1 : 2'd0);
          check("one_strobe", 64'($countones({mat_we, vec_we, cpu_go})), 64'd1);
          if (cpu_go) begin
            go_cyc = cyc;
            go_cnt++;
          end
          check("sb_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("strobe_kind", 64'(k), 64'(e.kind));
            if (e.kind != 2'd2) begin
              check("wr_addr", 64'(wr_addr), 64'(e.addr));
              check("wr_data", 64'(wr_data), 64'(e.data));
            end
          end
        end
      end
    join_none

    // Reset and idle: every output stays low.
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle_outputs", 64'({in_ready, mat_we, vec_we, wr_addr, wr_data, busy, cpu_go, err}), 64'd0);
    end
    // in_valid in IDLE is ignored.
    in_valid = 1'b1;
    in_data  = 32'hDEAD;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_ready", 64'({in_ready, busy}), 64'd0);
    end
    in_valid = 1'b0;

    // Back-to-back load.
    stream(1'b0, -1, sc);
    finish_load(sc, ROWS * COLS + COLS + 2);

    // Alternating valid: five idle cycles between the six words.
    stream(1'b1, -1, sc);
    finish_load(sc, ROWS * COLS + COLS + 2 + 5);

    // Reset after the third matrix word, then a fresh load from address 0.
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy_load", 64'(busy), 64'd1);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'(k + 1);
      push(2'd0, k, k + 1);
      step();
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    step();
    rst_n = 1'b1;
    check("rst_busy", 64'({busy, in_ready, mat_we, vec_we}), 64'd0);
    check("rst_sb", 64'(exp_q.size()), 64'd0);
    stream(1'b0, -1, sc);
    check("busy_after_load", 64'(busy), 64'd1);
    finish_load(sc, ROWS * COLS + COLS + 2);

    // start asserted mid-load is ignored.
    stream(1'b0, 2, sc);
    finish_load(sc, ROWS * COLS + COLS + 2);

`ifdef MV_LOADER_CHECKSUM_EN
    // Wrong checksum: err set, no cpu_go, back to IDLE.
    begin
      int go_before;
      go_before = go_cnt;
      stream(1'b0, -1, sc);
      in_valid = 1'b1;
      in_data  = 32'd20;
      step();
      in_valid = 1'b0;
      check("err_set", 64'(err), 64'd1);
      drain(5);
      step();
      step();
      check("bad_no_go", 64'(go_cnt - go_before), 64'd0);
      check("bad_idle", 64'({busy, in_ready}), 64'd0);
      check("err_sticky", 64'(err), 64'd1);
      // A new good load clears err.
      stream(1'b0, -1, sc);
      check("err_cleared_on_start", 64'(err), 64'd0);
      finish_load(sc, ROWS * COLS + COLS + 2);
    end
`endif

    repeat (3) step();
    check("sb_final", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
